// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// Included by the arbiter top and its round-robin picker.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'b00,
    ACCESS = 2'b01,
    RESP   = 2'b10
  } state_e;

  typedef enum logic {
    GNT_FETCH = 1'b0,
    GNT_DATA  = 1'b1
  } grant_e;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int CNT_W = 4;

endpackage

// File: rtl/arb2_rr.sv
// Two-requester round-robin picker: combinational pick, registered last grant.
// The last grant only moves when the owner accepts the pick via en.
module arb2_rr
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic req_f,
  input  logic req_d,
  input  logic en,
  output logic any_req,
  output logic pick_d,
  output logic last_d
);

  grant_e pick_s;
  grant_e last_r;

  // Pick the winner: a lone requester wins, a tie goes opposite the last grant
  always_comb begin
    pick_s = GNT_FETCH;
    if (req_f && req_d) begin
      if (last_r == GNT_FETCH) begin
        pick_s = GNT_DATA;
      end else begin
        pick_s = GNT_FETCH;
      end
    end else if (req_d) begin
      pick_s = GNT_DATA;
    end else begin
      pick_s = GNT_FETCH;
    end
  end

  // Remember the last accepted grant for the next tie
  always_ff @(posedge clk) begin
    if (rst) begin
      last_r <= GNT_FETCH;
    end else if (en && (req_f || req_d)) begin
      last_r <= pick_s;
    end else begin
      last_r <= last_r;
    end
  end

  assign any_req = req_f | req_d;
  assign pick_d  = (pick_s == GNT_DATA);
  assign last_d  = (last_r == GNT_DATA);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-port memory between the fetch and load/store paths,
// sequencing a fixed-latency access and returning a one-cycle acknowledge.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int WAIT_CYCLES = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ack,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_size,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              grant_d
);

  if ((WAIT_CYCLES < 1) || (WAIT_CYCLES > 15)) begin : g_bad_wait
    $error("mem_port_arbiter: WAIT_CYCLES must be within 1..15");
  end

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_CYCLES);

  state_e            state_r;
  state_e            state_nx_s;
  logic [CNT_W-1:0]  cnt_r;
  logic              grant_en_s;
  logic              any_req_s;
  logic              pick_d_s;
  logic              last_d_s;
  logic              cap_s;
  logic [ADDR_W-1:0] addr_r;
  logic [DATA_W-1:0] wdata_r;
  logic [DATA_W-1:0] rdata_r;
  logic              we_r;
  logic [1:0]        size_r;
  logic              mem_en_r;
  logic              mem_we_r;
  logic              if_ack_r;
  logic              d_ack_r;
  logic              busy_r;

  arb2_rr u_arb (
    .clk     (clk),
    .rst     (rst),
    .req_f   (if_req),
    .req_d   (d_req),
    .en      (grant_en_s),
    .any_req (any_req_s),
    .pick_d  (pick_d_s),
    .last_d  (last_d_s)
  );

  assign cap_s = (state_r == ACCESS) && (cnt_r == 4'd1);

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nx_s;
    end
  end

  // Next-state decode; requests are only looked at while idle
  always_comb begin
    state_nx_s = state_r;
    grant_en_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (any_req_s) begin
          grant_en_s = 1'b1;
          state_nx_s = ACCESS;
        end else begin
          state_nx_s = IDLE;
        end
      end
      ACCESS: begin
        if (cap_s) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = ACCESS;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // Latch the winner's request so later input churn cannot disturb the access
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= {ADDR_W{1'b0}};
      wdata_r <= {DATA_W{1'b0}};
      we_r    <= 1'b0;
      size_r  <= SZ_BYTE;
    end else if (grant_en_s) begin
      if (pick_d_s) begin
        addr_r  <= d_addr;
        wdata_r <= d_wdata;
        we_r    <= d_we;
        size_r  <= d_size;
      end else begin
        addr_r  <= if_addr;
        wdata_r <= {DATA_W{1'b0}};
        we_r    <= 1'b0;
        size_r  <= SZ_WORD;
      end
    end else begin
      addr_r  <= addr_r;
      wdata_r <= wdata_r;
      we_r    <= we_r;
      size_r  <= size_r;
    end
  end

  // Access-cycle counter and read-data capture on the last access cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r   <= {CNT_W{1'b0}};
      rdata_r <= {DATA_W{1'b0}};
    end else begin
      if (grant_en_s) begin
        cnt_r <= WAIT_INIT;
      end else if (state_r == ACCESS) begin
        cnt_r <= cnt_r - 4'd1;
      end else begin
        cnt_r <= cnt_r;
      end
      if (cap_s && !we_r) begin
        rdata_r <= mem_rdata;
      end else begin
        rdata_r <= rdata_r;
      end
    end
  end

  // Output flags registered from the next state so they align with it
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_en_r <= 1'b0;
      mem_we_r <= 1'b0;
      if_ack_r <= 1'b0;
      d_ack_r  <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      mem_en_r <= (state_nx_s == ACCESS);
      mem_we_r <= grant_en_s && pick_d_s && d_we;
      if_ack_r <= (state_nx_s == RESP) && !last_d_s;
      d_ack_r  <= (state_nx_s == RESP) && last_d_s;
      busy_r   <= (state_nx_s != IDLE);
    end
  end

  assign if_ack    = if_ack_r;
  assign d_ack     = d_ack_r;
  assign if_rdata  = rdata_r;
  assign d_rdata   = rdata_r;
  assign mem_en    = mem_en_r;
  assign mem_we    = mem_we_r;
  assign mem_size  = size_r;
  assign mem_addr  = addr_r;
  assign mem_wdata = wdata_r;
  assign busy      = busy_r;
  assign grant_d   = last_d_s;

endmodule
